// File: rtl/aes128_key_expand.sv
// AES-128 key expansion engine.
// A key_load captures the cipher key as round key 0. One further round key is
// then derived per clock until all 11 are stored. Stored keys are read
// combinationally through rk_index.
// Optional feature: define AES_KEYEXP_ZEROIZE_EN to add a zeroize input that
// wipes every stored key and returns the engine to IDLE.
module aes128_key_expand (
  input  logic         clk,
  input  logic         reset,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_load,
  input  logic [127:0] key,
  input  logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         key_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  // FIPS-197 forward S-box
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         r_state;
  state_t         w_state_next;
  logic [3:0]     r_round;
  logic [127:0]   r_rk [0:10];
  logic           w_zeroize;
  logic           w_load;
  logic [127:0]   w_prev;
  logic [31:0]    w_w0, w_w1, w_w2, w_w3;
  logic [127:0]   w_next_rk;

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign w_zeroize = zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  // A load is honoured only outside EXPAND, and zeroize outranks it.
  assign w_load = key_load && (r_state != EXPAND) && !w_zeroize;

  // Next-state logic: start on load, finish after round 10, zeroize to IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, READY: if (key_load) w_state_next = EXPAND;
      EXPAND:      if (r_round == 4'd10) w_state_next = READY;
      default:     w_state_next = IDLE;
    endcase
    if (w_zeroize) w_state_next = IDLE;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Select the previous round key rk[round-1] feeding the step.
  always_comb begin
    w_prev = '0;
    for (int i = 0; i < 10; i++)
      if (r_round == 4'(i + 1)) w_prev = r_rk[i];
  end

  // One key-schedule step: four chained words per round.
  always_comb begin
    w_w0      = w_prev[127:96] ^ sub_word({w_prev[23:0], w_prev[31:24]})
                ^ {rcon_of(r_round), 24'h0};
    w_w1      = w_prev[95:64] ^ w_w0;
    w_w2      = w_prev[63:32] ^ w_w1;
    w_w3      = w_prev[31:0]  ^ w_w2;
    w_next_rk = {w_w0, w_w1, w_w2, w_w3};
  end

  // Round-key storage and round counter.
  always_ff @(posedge clk) begin
    // NOTE: the key array is cleared on reset on purpose, so no key material
    // survives a reset; that makes it a flop array rather than a RAM.
    if (reset || w_zeroize) begin
      r_round <= 4'd0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else if (w_load) begin
      r_rk[0] <= key;
      r_round <= 4'd1;
    end else if (r_state == EXPAND) begin
      for (int i = 1; i < 11; i++)
        if (r_round == 4'(i)) r_rk[i] <= w_next_rk;
      r_round <= (r_round == 4'd10) ? 4'd0 : r_round + 4'd1;
    end
  end

  assign key_ready = (r_state == READY);
  assign busy      = (r_state == EXPAND);

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    round_key = '0;
    for (int i = 0; i < 11; i++)
      if (rk_index == 4'(i)) round_key = r_rk[i];
  end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand. The reference model derives the
// S-box from GF(2^8) inversion plus the affine map and runs the textbook
// 44-word key schedule. Define AES_KEYEXP_ZEROIZE_EN to cover zeroize too.
module tb_aes128_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic [127:0] key;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         key_ready;
  logic         busy;
`ifdef AES_KEYEXP_ZEROIZE_EN
  logic         zeroize;
`endif

  aes128_key_expand dut (
    .clk       (clk),
    .reset     (reset),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .key_load  (key_load),
    .key       (key),
    .rk_index  (rk_index),
    .round_key (round_key),
    .key_ready (key_ready),
    .busy      (busy)
  );

  always #20 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] got [16];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_rk(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Latch every index (0..15) into got[]; only used in stable states.
  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      rk_index = 4'(i);
      #1;
      got[i] = round_key;
    end
  endtask

  // Pulse key_load for one edge, then scramble the key bus.
  task automatic do_load(input logic [127:0] k);
    key      = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    key      = rand128();
  endtask

  // Count edges until key_ready, scrambling key each cycle; bounded at 20.
  task automatic wait_ready(output int n);
    n = 0;
    while (!key_ready && n < 20) begin
      tick();
      n++;
      key = rand128();
      checks++;
      if (key_ready && busy) begin
        failures++;
        $display("FAIL exclusive: key_ready=%0b busy=%0b both high", key_ready, busy);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; key_load = 1'b0; key = rand128(); rk_index = 4'd0;
`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: key_ready=%0b busy=%0b want 0 0", key_ready, busy);
    end
    read_all();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 128'h0) begin
        failures++;
        $display("FAIL reset_rk%0d: got=%h want=0", i, got[i]);
      end
    end
  endtask

  task automatic test_kat();
    logic [127:0] kk [3];
    logic [127:0] e1 [3];
    logic [127:0] e10 [3];
    int n;
    kk[0] = 128'h000102030405060708090a0b0c0d0e0f;
    e1[0] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    e10[0] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    kk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    e1[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    e10[1] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kk[2] = 128'h0;
    e1[2] = 128'h62636363626363636263636362636363;
    e10[2] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    for (int v = 0; v < 3; v++) begin
      do_load(kk[v]);
      checks++;
      if (busy !== 1'b1 || key_ready !== 1'b0) begin
        failures++;
        $display("FAIL kat%0d_start: busy=%0b key_ready=%0b want 1 0", v, busy, key_ready);
      end
      wait_ready(n);
      checks++;
      if (n != 10) begin
        failures++;
        $display("FAIL kat%0d_latency: got=%0d want=10", v, n);
      end
      read_all();
      checks++;
      if (got[0] !== kk[v] || got[1] !== e1[v] || got[10] !== e10[v]) begin
        failures++;
        $display("FAIL kat%0d_vec: rk0=%h rk1=%h rk10=%h want %h %h %h",
                 v, got[0], got[1], got[10], kk[v], e1[v], e10[v]);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got[i] !== ((i <= 10) ? model_rk(kk[v], i) : 128'h0)) begin
          failures++;
          $display("FAIL kat%0d_rk%0d: got=%h want=%h", v, i, got[i],
                   (i <= 10) ? model_rk(kk[v], i) : 128'h0);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] k;
    int n;
    for (int t = 0; t < 4; t++) begin
      k = rand128();
      do_load(k);
      wait_ready(n);
      checks++;
      if (n != 10) begin
        failures++;
        $display("FAIL rand%0d_latency: got=%0d want=10", t, n);
      end
      read_all();
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (got[i] !== model_rk(k, i)) begin
          failures++;
          $display("FAIL rand%0d_rk%0d: got=%h want=%h", t, i, got[i], model_rk(k, i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, kb;
    int n;
    ka = rand128();
    kb = rand128();
    // Second load mid-expansion must be ignored.
    do_load(ka);
    for (int c = 0; c < 4; c++) tick();
    key = kb; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    wait_ready(n);
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL ignore_load_latency: got=%0d want=5", n);
    end
    read_all();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got[i] !== model_rk(ka, i)) begin
        failures++;
        $display("FAIL ignore_load_rk%0d: got=%h want=%h", i, got[i], model_rk(ka, i));
      end
    end
    // Reload from READY restarts with the new key.
    do_load(kb);
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reload_drop: key_ready=%0b busy=%0b want 0 1", key_ready, busy);
    end
    wait_ready(n);
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL reload_latency: got=%0d want=10", n);
    end
    read_all();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got[i] !== model_rk(kb, i)) begin
        failures++;
        $display("FAIL reload_rk%0d: got=%h want=%h", i, got[i], model_rk(kb, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_load(rand128());
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_flags: key_ready=%0b busy=%0b want 0 0", key_ready, busy);
    end
    read_all();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 128'h0) begin
        failures++;
        $display("FAIL reset_mid_rk%0d: got=%h want=0", i, got[i]);
      end
    end
    // Reset outranks a simultaneous load.
    key = rand128(); key_load = 1'b1; reset = 1'b1;
    tick();
    key_load = 1'b0; reset = 1'b0;
    tick();
    rk_index = 4'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0 || round_key !== 128'h0) begin
      failures++;
      $display("FAIL reset_prio: busy=%0b key_ready=%0b rk0=%h want 0 0 0",
               busy, key_ready, round_key);
    end
  endtask

`ifdef AES_KEYEXP_ZEROIZE_EN
  task automatic test_zeroize();
    int n;
    do_load(rand128());
    wait_ready(n);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zeroize_flags: key_ready=%0b busy=%0b want 0 0", key_ready, busy);
    end
    read_all();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 128'h0) begin
        failures++;
        $display("FAIL zeroize_rk%0d: got=%h want=0", i, got[i]);
      end
    end
    key = rand128(); key_load = 1'b1; zeroize = 1'b1;
    tick();
    key_load = 1'b0; zeroize = 1'b0;
    tick();
    rk_index = 4'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0 || round_key !== 128'h0) begin
      failures++;
      $display("FAIL zeroize_prio: busy=%0b key_ready=%0b rk0=%h want 0 0 0",
               busy, key_ready, round_key);
    end
  endtask
`endif

  initial begin
    build_sbox();
    test_reset();
    test_kat();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_KEYEXP_ZEROIZE_EN
    test_zeroize();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
